// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and the memory.
// The unit drives the request; the memory returns ack and read data.
interface mem_access_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    output dmem_be_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    input  dmem_be_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage load/store unit: IDLE/REQ/DONE bus sequencer with lane steering.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/half accesses.
module mem_access_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              clear,
  input  logic              M_mem_rd_i,
  input  logic              M_mem_wr_i,
  input  logic [1:0]        M_size_i,
  input  logic              M_unsigned_i,
  input  logic [31:0]       M_alu_res_i,
  input  logic [31:0]       M_store_data_i,
  input  logic [4:0]        M_rd_i,
  input  logic              M_w_reg_ena_i,
  input  logic              M_wb_sel_i,
  input  logic [31:0]       M_PC_i,
  output logic [31:0]       mem_data_o,
  output logic [31:0]       alu_res_o,
  output logic [31:0]       PC_o,
  output logic [4:0]        rd_o,
  output logic              w_reg_ena_o,
  output logic              wb_sel_o,
  output logic              mem_stall_o,
  output logic              misalign_o,
  mem_access_unit_if.master dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  logic [31:0] r_alu;
  logic [31:0] r_pc;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_data;
  logic [4:0]  r_rd;
  logic [3:0]  r_be;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_ld;
  logic        r_uns;
  logic        r_wen;
  logic        r_wbs;
  logic        r_killed;

  logic [1:0]  w_off;
  logic [31:0] w_shift;
  logic [31:0] w_ld_data;
  logic        w_in_req;

  assign w_is_byte = (M_size_i == 2'b00);
  assign w_is_half = (M_size_i == 2'b01);
  assign w_is_word = M_size_i[1];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = (M_mem_rd_i | M_mem_wr_i) &
                      ((w_is_word & (|M_alu_res_i[1:0])) |
                       (w_is_half & M_alu_res_i[0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = (M_mem_rd_i | M_mem_wr_i) & ~clear & ~w_misalign;

  // Byte enables and lane-replicated store data from the live address
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = M_store_data_i;
    unique case (1'b1)
      w_is_byte: begin
        w_be    = 4'b0001 << M_alu_res_i[1:0];
        w_wdata = {4{M_store_data_i[7:0]}};
      end
      w_is_half: begin
        w_be    = M_alu_res_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{M_store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = M_store_data_i;
      end
    endcase
  end

  // Byte offset of the loaded lane; words always start at lane 0
  always_comb begin
    w_off = 2'b00;
    unique case (1'b1)
      (r_size == 2'b00): w_off = r_alu[1:0];
      (r_size == 2'b01): w_off = {r_alu[1], 1'b0};
      default:           w_off = 2'b00;
    endcase
  end

  assign w_shift = dmem.dmem_rdata_i >> {w_off, 3'b000};

  // Sign- or zero-extend the selected lane
  always_comb begin
    w_ld_data = w_shift;
    unique case (1'b1)
      (r_size == 2'b00):
        w_ld_data = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
      (r_size == 2'b01):
        w_ld_data = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default:
        w_ld_data = w_shift;
    endcase
  end

  assign w_in_req          = (r_state == S_REQ);
  assign dmem.dmem_req_o   = w_in_req;
  assign dmem.dmem_we_o    = w_in_req & r_we;
  assign dmem.dmem_addr_o  = w_in_req ? {r_alu[31:2], 2'b00} : 32'h0;
  assign dmem.dmem_wdata_o = w_in_req ? r_wdata : 32'h0;
  assign dmem.dmem_be_o    = w_in_req ? r_be : 4'b0000;

  // Next state and MEM/WB-facing outputs
  always_comb begin
    w_next      = r_state;
    mem_stall_o = 1'b0;
    misalign_o  = 1'b0;
    mem_data_o  = 32'h0;
    alu_res_o   = M_alu_res_i;
    PC_o        = M_PC_i;
    rd_o        = M_rd_i;
    wb_sel_o    = M_wb_sel_i;
    w_reg_ena_o = M_w_reg_ena_i & ~clear & ~w_misalign;
    unique case (r_state)
      S_IDLE: begin
        misalign_o = w_misalign;
        if (w_access) begin
          mem_stall_o = 1'b1;
          w_next      = S_REQ;
        end
      end
      S_REQ: begin
        mem_stall_o = 1'b1;
        mem_data_o  = r_mem_data;
        alu_res_o   = r_alu;
        PC_o        = r_pc;
        rd_o        = r_rd;
        wb_sel_o    = r_wbs;
        w_reg_ena_o = 1'b0;
        if (dmem.dmem_ack_i) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        mem_data_o  = r_mem_data;
        alu_res_o   = r_alu;
        PC_o        = r_pc;
        rd_o        = r_rd;
        wb_sel_o    = r_wbs;
        w_reg_ena_o = r_wen & ~r_killed & ~clear;
        if (!stall_i) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Reset overrides the combinational flags immediately
    if (!rst) begin
      mem_stall_o = 1'b0;
      misalign_o  = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the instruction on issue, load data on ack, kill on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu      <= 32'h0;
      r_pc       <= 32'h0;
      r_wdata    <= 32'h0;
      r_mem_data <= 32'h0;
      r_rd       <= 5'h0;
      r_be       <= 4'h0;
      r_size     <= 2'b00;
      r_we       <= 1'b0;
      r_ld       <= 1'b0;
      r_uns      <= 1'b0;
      r_wen      <= 1'b0;
      r_wbs      <= 1'b0;
      r_killed   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_alu      <= M_alu_res_i;
            r_pc       <= M_PC_i;
            r_wdata    <= w_wdata;
            r_mem_data <= 32'h0;
            r_rd       <= M_rd_i;
            r_be       <= w_be;
            r_size     <= M_size_i;
            r_we       <= M_mem_wr_i;
            r_ld       <= M_mem_rd_i;
            r_uns      <= M_unsigned_i;
            r_wen      <= M_w_reg_ena_i;
            r_wbs      <= M_wb_sel_i;
            r_killed   <= 1'b0;
          end
        end
        S_REQ: begin
          if (clear) begin
            r_killed <= 1'b1;
          end
          if (dmem.dmem_ack_i) begin
            r_mem_data <= r_ld ? w_ld_data : 32'h0;
          end
        end
        S_DONE: begin
          if (clear) begin
            r_killed <= 1'b1;
          end
        end
        default: begin
          r_killed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-level memory model.
// A responder serves the bus with per-transaction ack delays.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        clear = 1'b0;
  logic        M_mem_rd_i = 1'b0;
  logic        M_mem_wr_i = 1'b0;
  logic [1:0]  M_size_i = 2'b00;
  logic        M_unsigned_i = 1'b0;
  logic [31:0] M_alu_res_i = 32'h0;
  logic [31:0] M_store_data_i = 32'h0;
  logic [4:0]  M_rd_i = 5'h0;
  logic        M_w_reg_ena_i = 1'b0;
  logic        M_wb_sel_i = 1'b0;
  logic [31:0] M_PC_i = 32'h0;
  logic [31:0] mem_data_o;
  logic [31:0] alu_res_o;
  logic [31:0] PC_o;
  logic [4:0]  rd_o;
  logic        w_reg_ena_o;
  logic        wb_sel_o;
  logic        mem_stall_o;
  logic        misalign_o;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .clear         (clear),
    .M_mem_rd_i    (M_mem_rd_i),
    .M_mem_wr_i    (M_mem_wr_i),
    .M_size_i      (M_size_i),
    .M_unsigned_i  (M_unsigned_i),
    .M_alu_res_i   (M_alu_res_i),
    .M_store_data_i(M_store_data_i),
    .M_rd_i        (M_rd_i),
    .M_w_reg_ena_i (M_w_reg_ena_i),
    .M_wb_sel_i    (M_wb_sel_i),
    .M_PC_i        (M_PC_i),
    .mem_data_o    (mem_data_o),
    .alu_res_o     (alu_res_o),
    .PC_o          (PC_o),
    .rd_o          (rd_o),
    .w_reg_ena_o   (w_reg_ena_o),
    .wb_sel_o      (wb_sel_o),
    .mem_stall_o   (mem_stall_o),
    .misalign_o    (misalign_o),
    .dmem          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        wbs;
    logic        mis;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } bus_t;

  exp_t       sbq[$];
  bus_t       busq[$];
  int         dlyq[$];
  logic [7:0] rmem[int];
  logic [31:0] bmem[int];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tb_live = 1'b0;
  int   scnt = 0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] initb(input int a);
    return 8'((a * 37) ^ (a >> 3) ^ 90);
  endfunction

  function automatic logic [7:0] rd_b(input int a);
    return rmem.exists(a) ? rmem[a] : initb(a);
  endfunction

  function automatic logic [31:0] rd_w(input int a);
    if (bmem.exists(a)) return bmem[a];
    return {initb(a + 3), initb(a + 2), initb(a + 1), initb(a)};
  endfunction

  task automatic preload(input int a, input logic [31:0] w);
    bmem[a] = w;
    for (int i = 0; i < 4; i++) rmem[a + i] = 8'(w >> (8 * i));
  endtask

  // Monitor: pops one expectation per retiring instruction
  always @(negedge clk) begin
    if (tb_live && rst) begin
      if (mem_stall_o) begin
        scnt++;
      end else if (!stall_i) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got output expected none at %0t", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("mem_data", mem_data_o, mon_e.mem);
          chk("alu_res", alu_res_o, mon_e.alu);
          chk("pc", PC_o, mon_e.pc);
          chk("rd", 32'(rd_o), 32'(mon_e.rd));
          chk("w_reg_ena", 32'(w_reg_ena_o), 32'(mon_e.wen));
          chk("wb_sel", 32'(wb_sel_o), 32'(mon_e.wbs));
          chk("misalign", 32'(misalign_o), 32'(mon_e.mis));
          chk("stall_cycles", scnt, mon_e.stalls);
        end
        scnt = 0;
      end
    end
  end

  // Memory responder: checks bus requests, acks after the queued delay
  initial begin : responder
    bit          busy;
    int          cnt;
    int          d;
    bus_t        first;
    bus_t        x;
    logic [31:0] w;
    busy = 1'b0;
    cnt  = 0;
    d    = 0;
    bus.dmem_ack_i   = 1'b0;
    bus.dmem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.dmem_ack_i = 1'b0;
      if (!bus.dmem_req_o) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          d    = (dlyq.size() != 0) ? dlyq.pop_front() : 0;
          first.addr  = bus.dmem_addr_o;
          first.wdata = bus.dmem_wdata_o;
          first.be    = bus.dmem_be_o;
          first.we    = bus.dmem_we_o;
          if (busq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got req at %h expected none",
                     bus.dmem_addr_o);
          end else begin
            x = busq.pop_front();
            chk("bus_addr", first.addr, x.addr);
            chk("bus_be", 32'(first.be), 32'(x.be));
            chk("bus_we", 32'(first.we), 32'(x.we));
            if (x.we) chk("bus_wdata", first.wdata, x.wdata);
          end
        end else begin
          chk("hold_addr", bus.dmem_addr_o, first.addr);
          chk("hold_wdata", bus.dmem_wdata_o, first.wdata);
          chk("hold_be_we", {bus.dmem_be_o, bus.dmem_we_o},
              {first.be, first.we});
        end
        if (cnt == d) begin
          w = rd_w(int'(first.addr));
          bus.dmem_ack_i   = 1'b1;
          bus.dmem_rdata_i = w;
          if (first.we) begin
            for (int j = 0; j < 4; j++)
              if (first.be[j]) w[8*j +: 8] = first.wdata[8*j +: 8];
            bmem[int'(first.addr)] = w;
          end
          busy = 1'b0;
        end
        cnt++;
      end
    end
  end

  // One instruction: model expectation, then drive until it retires.
  // mode 0 plain, 1 clear throughout, 2 clear in first REQ cycle,
  // 3 clear once the result is presented.
  task automatic run_instr(input bit rd_, input bit wr_,
                           input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] rdn, input bit wen,
                           input bit wbs, input logic [31:0] pc,
                           input int mode_in, input int dly);
    exp_t   e;
    bus_t   b;
    int     n;
    int     ea;
    int     mode;
    int     holds;
    bit     mis;
    bit     acc;
    bit     retire;
    longint v;
    mode = mode_in;
    if (!(rd_ | wr_) && mode == 2) mode = 0;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (rd_ | wr_) && (int'(addr) % n != 0);
`endif
    acc = (rd_ | wr_) && mode != 1 && !mis;
    ea  = int'(addr) - (int'(addr) % n);
    e.mem    = 32'h0;
    e.alu    = addr;
    e.pc     = pc;
    e.rd     = rdn;
    e.wbs    = wbs;
    e.wen    = wen && mode == 0 && !mis;
    e.mis    = mis;
    e.stalls = acc ? 2 + dly : 0;
    if (acc) begin
      b.addr  = 32'(ea - (ea % 4));
      b.be    = 4'b0000;
      b.we    = wr_;
      b.wdata = 32'h0;
      for (int i = 0; i < n; i++) b.be[(ea % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = 8'(sd >> (8 * (j % n)));
      if (rd_) begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v | (longint'(rd_b(ea + i)) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        e.mem = v[31:0];
      end else begin
        for (int i = 0; i < n; i++) rmem[ea + i] = 8'(sd >> (8 * i));
      end
      busq.push_back(b);
      dlyq.push_back(dly);
    end
    sbq.push_back(e);

    M_mem_rd_i     = rd_;
    M_mem_wr_i     = wr_;
    M_size_i       = sz;
    M_unsigned_i   = uns;
    M_alu_res_i    = addr;
    M_store_data_i = sd;
    M_rd_i         = rdn;
    M_w_reg_ena_i  = wen;
    M_wb_sel_i     = wbs;
    M_PC_i         = pc;
    clear          = 1'b0;
    stall_i        = 1'b0;
    tb_live        = 1'b1;
    holds          = 0;
    retire         = 1'b0;
    for (int c = 0; c <= 60 && !retire; c++) begin
      if (mode == 1) clear = 1'b1;
      else if (mode == 2) clear = (c == 1);
      #1;
      if (mode == 3 && !mem_stall_o) begin
        clear = 1'b1;
        #1;
      end
      if (!mem_stall_o && holds < 2 && $urandom_range(0, 3) == 0) begin
        stall_i = 1'b1;
        holds++;
      end else begin
        stall_i = 1'b0;
      end
      @(negedge clk);
      retire = !mem_stall_o && !stall_i;
      @(posedge clk);
      #1;
    end
    if (!retire) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no retire expected retire pc %h", pc);
    end
    tb_live    = 1'b0;
    M_mem_rd_i = 1'b0;
    M_mem_wr_i = 1'b0;
    clear      = 1'b0;
    stall_i    = 1'b0;
  endtask

  initial begin : main
    int   kind;
    int   mode;
    bus_t rb;
    #3;
    chk("rst_stall", 32'(mem_stall_o), 32'h0);
    chk("rst_req", 32'(bus.dmem_req_o), 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    preload(32'h100, 32'hDEADBEEF);
    run_instr(1, 0, 2'b10, 0, 32'h100, 0, 5'd5, 1, 1, 32'h40, 0, 0);
    preload(32'h100, 32'h80112233);
    run_instr(1, 0, 2'b00, 0, 32'h103, 0, 5'd6, 1, 1, 32'h44, 0, 0);
    run_instr(1, 0, 2'b00, 1, 32'h103, 0, 5'd7, 1, 1, 32'h48, 0, 1);
    run_instr(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 5'd0, 0, 0,
              32'h4C, 0, 3);
    run_instr(1, 0, 2'b01, 0, 32'h202, 0, 5'd8, 1, 1, 32'h50, 0, 0);
    run_instr(1, 0, 2'b10, 0, 32'h100, 0, 5'd9, 1, 1, 32'h54, 2, 2);
    run_instr(0, 0, 2'b10, 0, 32'h12345678, 0, 5'd10, 1, 0, 32'h58, 0, 0);
    run_instr(1, 0, 2'b10, 0, 32'h100, 0, 5'd11, 1, 1, 32'h5C, 1, 0);
    run_instr(1, 0, 2'b10, 0, 32'h101, 0, 5'd12, 1, 1, 32'h60, 0, 0);

    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 2);
      mode = $urandom_range(0, 5);
      mode = (mode < 3) ? 0 : mode - 2;
      run_instr(kind == 1, kind == 2, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                32'h1000 + 32'($urandom_range(0, 63)), $urandom,
                5'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom, mode,
                $urandom_range(0, 3));
    end

    rb.addr  = 32'h1F0;
    rb.be    = 4'b1111;
    rb.we    = 1'b0;
    rb.wdata = 32'h0;
    busq.push_back(rb);
    dlyq.push_back(30);
    M_mem_rd_i    = 1'b1;
    M_size_i      = 2'b10;
    M_alu_res_i   = 32'h1F0;
    M_w_reg_ena_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(bus.dmem_req_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.dmem_req_o), 32'h0);
    chk("midrst_stall", 32'(mem_stall_o), 32'h0);
    chk("midrst_misalign", 32'(misalign_o), 32'h0);
    chk("midrst_mem_data", mem_data_o, 32'h0);
    M_mem_rd_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_stall", 32'(mem_stall_o), 32'h0);
    chk("postrst_req", 32'(bus.dmem_req_o), 32'h0);
    run_instr(1, 0, 2'b10, 0, 32'h1F0, 0, 5'd3, 1, 0, 32'h80, 0, 0);

    chk("sb_drained", sbq.size(), 0);
    chk("bus_drained", busq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low (0 = reset).
REQ-003 The block SHALL have port stall_i, input, 1 bit: downstream MEM/WB register not accepting (hold).
REQ-004 The block SHALL have port clear, input, 1 bit: flush the current instruction.
REQ-005 The block SHALL have ports M_mem_rd_i and M_mem_wr_i, inputs, 1 bit each: load access / store access.
REQ-006 The block SHALL have port M_size_i, input, 2 bits: access size, 00 = byte, 01 = half, 10 = word (11 treated as word).
REQ-007 The block SHALL have port M_unsigned_i, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-008 The block SHALL have ports M_alu_res_i (32 bits, address/ALU result) and M_store_data_i (32 bits), inputs.
REQ-009 The block SHALL have ports M_rd_i (5 bits), M_w_reg_ena_i (1 bit), M_wb_sel_i (1 bit) and M_PC_i (32 bits), inputs.
REQ-010 The block SHALL have outputs mem_data_o, alu_res_o and PC_o (32 bits each), rd_o (5 bits), and w_reg_ena_o and wb_sel_o (1 bit each), all feeding the MEM/WB register.
REQ-011 The block SHALL have output mem_stall_o, 1 bit: freeze the upstream pipeline.
REQ-012 The block SHALL have output misalign_o, 1 bit: misaligned-access flag.
REQ-013 The block SHALL have data bus ports dmem_req_o (1), dmem_we_o (1), dmem_addr_o (32), dmem_wdata_o (32) and dmem_be_o (4) as outputs, and dmem_ack_i (1) and dmem_rdata_i (32) as inputs.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, REQ and DONE.
REQ-015 In IDLE with access = (M_mem_rd_i|M_mem_wr_i) & ~clear, the block SHALL assert mem_stall_o combinationally and go to REQ on the next edge.
REQ-016 In IDLE with no access, the block SHALL drive the data bus inactive, pass alu_res, rd, w_reg_ena, wb_sel and PC straight through, and hold mem_data_o at 0.
REQ-017 In REQ, the block SHALL assert dmem_req_o and keep dmem_addr_o, dmem_we_o, dmem_wdata_o and dmem_be_o stable until the cycle in which dmem_ack_i = 1.
REQ-018 In REQ, the block SHALL keep mem_stall_o = 1.
REQ-019 On ack, the block SHALL register the formatted load data and go to DONE.
REQ-020 With a zero-wait ack, mem_stall_o SHALL be high for exactly 2 cycles.
REQ-021 In DONE, the block SHALL drive mem_stall_o = 0 and outputs = captured instruction; it SHALL stay in DONE while stall_i = 1 and go to IDLE when stall_i = 0.
REQ-022 Address and byte enables SHALL be: dmem_addr_o = {addr[31:2],2'b00}; byte: be = 1 << addr[1:0]; half: be = 0011 or 1100 by addr[1]; word: be = 1111.
REQ-023 Store data SHALL be replicated into the selected lanes (byte x4, half x2).
REQ-024 A load SHALL select the lane by addr[1:0], then sign- or zero-extend to 32 bits per M_unsigned_i.
REQ-025 clear in REQ SHALL NOT drop dmem_req_o before ack (the bus transaction completes); the instruction is marked killed and DONE presents w_reg_ena_o = 0.
REQ-026 clear in IDLE or DONE SHALL force w_reg_ena_o = 0 for that instruction.

Reset
REQ-027 rst = 0 SHALL immediately force IDLE, dmem_req_o = 0, mem_stall_o = 0, misalign_o = 0, all registered data = 0 and the killed flag = 0, including mid-transaction.

Configuration
REQ-028 With MEM_ALIGN_CHECK_EN defined, a misaligned access (word with addr[1:0] != 0, half with addr[0] != 0) detected in IDLE SHALL issue no bus request, set misalign_o = 1 and w_reg_ena_o = 0 for that cycle, and keep mem_stall_o = 0.
REQ-029 With MEM_ALIGN_CHECK_EN undefined, misalign_o SHALL be tied to 0, and word/half accesses SHALL ignore the low address bits (treated as aligned).

Verification
REQ-030 Word load, addr 0x100, rdata 0xDEADBEEF, ack in the first REQ cycle -> stall 2 cycles, then mem_data_o = 0xDEADBEEF, be = 1111.
REQ-031 Signed byte load, addr 0x103, rdata 0x80112233 -> be = 1000, mem_data_o = 0xFFFFFF80; the same with M_unsigned_i = 1 -> 0x00000080.
REQ-032 Half store, addr 0x202, data 0x0000ABCD, ack delayed 3 cycles -> be = 1100, wdata = 0xABCDABCD, req and addr stable for 4 cycles, stall 5 cycles.
REQ-033 clear asserted in REQ, ack 2 cycles later -> req held until ack, DONE shows w_reg_ena_o = 0.
REQ-034 rst asserted in REQ -> dmem_req_o and mem_stall_o = 0 immediately; after release, state is IDLE.
REQ-035 With MEM_ALIGN_CHECK_EN defined, word load at 0x101 -> no dmem_req_o, misalign_o = 1, w_reg_ena_o = 0, no stall.
